// File: rtl/circuit_breaker.sv
// circuit_breaker: trading-halt controller gating trade requests through NORMAL / HALT / COOLDOWN.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   cb_load          - one-cycle trip/extend pulse from the cascade detector
//   cb_param[7:0]    - requested halt length, sampled with cb_load
//   rule_alert_any   - rule alert valid; with rule_alert_type==3 it is a FLASH_CRASH strike
//   rule_alert_type  - rule alert code
//   trade_req        - trade request for this cycle
//   manual_resume    - operator early release from HALT
//   trade_grant      - registered grant for the previous cycle's request
//   trade_halt       - high while in HALT
//   cb_state[1:0]    - 0 NORMAL, 1 HALT, 2 COOLDOWN
//   cb_remaining     - cycles left in HALT/COOLDOWN, 0 in NORMAL
//   halt_events      - saturating count of HALT entries
module circuit_breaker #(
    parameter int MIN_HALT      = 16,
    parameter int COOLDOWN_CYC  = 32,
    parameter int THROTTLE_DIV  = 4,
    parameter int STRIKE_LIMIT  = 3,
    parameter int STRIKE_WINDOW = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cb_load,
    input  logic [7:0] cb_param,
    input  logic       rule_alert_any,
    input  logic [2:0] rule_alert_type,
    input  logic       trade_req,
    input  logic       manual_resume,
    output logic       trade_grant,
    output logic       trade_halt,
    output logic [1:0] cb_state,
    output logic [7:0] cb_remaining,
    output logic [7:0] halt_events
);
    typedef enum logic [1:0] {NORMAL = 2'd0, HALT = 2'd1, COOLDOWN = 2'd2} state_t;
    localparam logic [7:0]  MIN_H       = 8'(MIN_HALT);
    localparam logic [7:0]  CD          = 8'(COOLDOWN_CYC);
    localparam logic [3:0]  THR_LAST    = 4'(THROTTLE_DIV - 1);
    localparam logic [2:0]  STRIKE_LAST = 3'(STRIKE_LIMIT - 1);
    localparam logic [10:0] WIN         = 11'(STRIKE_WINDOW);
    state_t      state_q, state_d;
    logic [7:0]  rem_q, rem_d, events_q, events_d, enter_rem, dur, dec;
    logic [2:0]  strike_q, strike_d;
    logic [10:0] idle_q, idle_d;
    logic [3:0]  thr_q, thr_d;
    logic        grant_q, grant_d, strike, enter;
    assign dur    = (cb_param < MIN_H) ? MIN_H : cb_param;
    assign dec    = (rem_q == 8'd0) ? 8'd0 : rem_q - 8'd1;
    assign strike = rule_alert_any && (rule_alert_type == 3'd3);
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        events_d  = events_q;
        strike_d  = strike_q;
        idle_d    = idle_q;
        thr_d     = thr_q;
        enter     = 1'b0;
        enter_rem = rem_q;
        // grant reflects the state in the cycle the request was sampled
        grant_d = (state_q == NORMAL)   ? trade_req :
                  (state_q == COOLDOWN) ? (trade_req && thr_q == 4'd0) : 1'b0;
        unique case (state_q)
            NORMAL: begin
                if (cb_load) begin
                    enter     = 1'b1;
                    enter_rem = dur;
                end else if (strike) begin
                    if (strike_q == STRIKE_LAST) begin
                        enter     = 1'b1;
                        enter_rem = 8'hFF;
                    end else begin
                        strike_d = strike_q + 3'd1;
                        idle_d   = 11'd0;
                    end
                end else begin
                    // idle timer saturates at the window so it never wraps
                    idle_d = (idle_q == WIN) ? idle_q : idle_q + 11'd1;
                    if (idle_d == WIN) strike_d = 3'd0;
                end
            end
            HALT: begin
                if (cb_load) rem_d = (dec > dur) ? dec : dur;
                else if (manual_resume || rem_q <= 8'd1) begin
                    state_d = COOLDOWN;
                    rem_d   = CD;
                end else rem_d = dec;
            end
            COOLDOWN: begin
                if (cb_load) begin
                    enter     = 1'b1;
                    enter_rem = dur;
                end else if (strike) begin
                    enter     = 1'b1;
                    enter_rem = MIN_H;
                end else begin
                    if (trade_req) thr_d = (thr_q == THR_LAST) ? 4'd0 : thr_q + 4'd1;
                    if (rem_q <= 8'd1) begin
                        state_d = NORMAL;
                        rem_d   = 8'd0;
                    end else rem_d = dec;
                end
            end
            default: begin
                state_d = NORMAL;
                rem_d   = 8'd0;
            end
        endcase
        if (enter) begin
            state_d  = HALT;
            rem_d    = enter_rem;
            events_d = (events_q == 8'hFF) ? events_q : events_q + 8'd1;
            strike_d = 3'd0;
            thr_d    = 4'd0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            rem_q    <= 8'd0;
            events_q <= 8'd0;
            strike_q <= 3'd0;
            idle_q   <= 11'd0;
            thr_q    <= 4'd0;
            grant_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            events_q <= events_d;
            strike_q <= strike_d;
            idle_q   <= idle_d;
            thr_q    <= thr_d;
            grant_q  <= grant_d;
        end
    end
    assign trade_grant  = grant_q;
    assign trade_halt   = (state_q == HALT);
    assign cb_state     = state_q;
    assign cb_remaining = rem_q;
    assign halt_events  = events_q;
endmodule

// File: tb/tb_circuit_breaker.sv
// tb_circuit_breaker: directed self-checking bench for circuit_breaker.
module tb_circuit_breaker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cb_load = 1'b0;
    logic [7:0] cb_param = 8'd0;
    logic       rule_alert_any = 1'b0;
    logic [2:0] rule_alert_type = 3'd0;
    logic       trade_req = 1'b0;
    logic       manual_resume = 1'b0;
    logic       trade_grant, trade_halt;
    logic [1:0] cb_state;
    logic [7:0] cb_remaining, halt_events;
    int checks = 0;
    int failures = 0;

    circuit_breaker dut (
        .clk(clk), .rst_n(rst_n), .cb_load(cb_load), .cb_param(cb_param),
        .rule_alert_any(rule_alert_any), .rule_alert_type(rule_alert_type),
        .trade_req(trade_req), .manual_resume(manual_resume),
        .trade_grant(trade_grant), .trade_halt(trade_halt), .cb_state(cb_state),
        .cb_remaining(cb_remaining), .halt_events(halt_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cb_load = 1'b0;
        cb_param = 8'd0;
        rule_alert_any = 1'b0;
        rule_alert_type = 3'd0;
        trade_req = 1'b0;
        manual_resume = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] p);
        cb_load = 1'b1;
        cb_param = p;
        tick();
        cb_load = 1'b0;
    endtask

    task automatic alert(input logic [2:0] t);
        rule_alert_any = 1'b1;
        rule_alert_type = t;
        tick();
        rule_alert_any = 1'b0;
    endtask

    initial begin
        int pat[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        // 1: reset state and pass-through
        do_reset();
        chk("rst_grant", trade_grant, 0);
        chk("rst_halt", trade_halt, 0);
        chk("rst_state", cb_state, 0);
        chk("rst_rem", cb_remaining, 0);
        chk("rst_events", halt_events, 0);
        trade_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pass_grant", trade_grant, 1);
        end
        chk("pass_state", cb_state, 0);
        chk("pass_events", halt_events, 0);
        // 2: halt of 40, cooldown of 32; request alongside cb_load still granted
        load(8'd40);
        chk("h40_grant_same", trade_grant, 1);
        chk("h40_state", cb_state, 1);
        chk("h40_halt", trade_halt, 1);
        chk("h40_rem", cb_remaining, 40);
        chk("h40_events", halt_events, 1);
        tick();
        chk("h40_grant_blocked", trade_grant, 0);
        chk("h40_rem39", cb_remaining, 39);
        trade_req = 1'b0;
        tick(38);
        chk("h40_last_state", cb_state, 1);
        chk("h40_last_rem", cb_remaining, 1);
        tick();
        chk("cd_state", cb_state, 2);
        chk("cd_rem", cb_remaining, 32);
        chk("cd_halt", trade_halt, 0);
        tick(31);
        chk("cd_last_state", cb_state, 2);
        tick();
        chk("norm_state", cb_state, 0);
        chk("norm_rem", cb_remaining, 0);
        // 3: MIN_HALT floor and extension without a new event
        do_reset();
        load(8'd5);
        chk("min_rem", cb_remaining, 16);
        tick(6);
        chk("ext_pre_rem", cb_remaining, 10);
        load(8'd100);
        chk("ext_rem", cb_remaining, 100);
        chk("ext_events", halt_events, 1);
        load(8'd5);
        chk("noshort_rem", cb_remaining, 99);
        chk("noshort_state", cb_state, 1);
        // 4: strikes 10 apart trip; non-FLASH alerts do nothing
        do_reset();
        for (int i = 0; i < 3; i++) alert(3'd2);
        chk("nonflash_state", cb_state, 0);
        alert(3'd3);
        tick(9);
        alert(3'd3);
        chk("strike2_state", cb_state, 0);
        tick(9);
        alert(3'd3);
        chk("strike3_state", cb_state, 1);
        chk("strike3_rem", cb_remaining, 255);
        chk("strike3_events", halt_events, 1);
        do_reset();
        alert(3'd3);
        tick(300);
        alert(3'd3);
        tick(300);
        alert(3'd3);
        chk("slow_state", cb_state, 0);
        chk("slow_events", halt_events, 0);
        // 5: throttled grants in cooldown, then strike re-trips with MIN_HALT
        do_reset();
        load(8'd0);
        chk("p0_rem", cb_remaining, 16);
        tick(16);
        chk("thr_state", cb_state, 2);
        trade_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("thr_grant%0d", i), trade_grant, pat[i]);
        end
        trade_req = 1'b0;
        chk("thr_rem", cb_remaining, 24);
        alert(3'd3);
        chk("cdstrike_state", cb_state, 1);
        chk("cdstrike_rem", cb_remaining, 16);
        chk("cdstrike_events", halt_events, 2);
        // 6: manual resume, load-over-resume, async reset mid-HALT
        do_reset();
        load(8'd60);
        tick(10);
        chk("mr_pre_rem", cb_remaining, 50);
        manual_resume = 1'b1;
        tick();
        manual_resume = 1'b0;
        chk("mr_state", cb_state, 2);
        chk("mr_rem", cb_remaining, 32);
        manual_resume = 1'b1;
        tick();
        manual_resume = 1'b0;
        chk("mr_cd_ignored", cb_state, 2);
        load(8'd60);
        chk("mr2_events", halt_events, 2);
        tick(10);
        manual_resume = 1'b1;
        load(8'd20);
        manual_resume = 1'b0;
        chk("mrload_state", cb_state, 1);
        chk("mrload_rem", cb_remaining, 49);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", cb_state, 0);
        chk("arst_halt", trade_halt, 0);
        chk("arst_rem", cb_remaining, 0);
        chk("arst_events", halt_events, 0);
        chk("arst_grant", trade_grant, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
